// File: rtl/hazard_sequencer.sv
// hazard_sequencer: stall/flush/forward control for the 5-stage RV32I pipeline.
// Optional HAZ_PERF_CNT_EN adds the stall_cycles / flush_events counters.
module hazard_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      ResultSrcE0,
    input  logic                      PCSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      mem_req_M,
    input  logic                      mem_ready_M,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      mem_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0]     stall_cycles,
    output logic [DATA_WIDTH-1:0]     flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TO_CNT  = CNT_WIDTH'(TIMEOUT_CYCLES);

    if ((2 ** CNT_WIDTH) <= TIMEOUT_CYCLES || DATA_WIDTH < 1) begin : g_param_chk
        $error("hazard_sequencer: CNT_WIDTH too small for TIMEOUT_CYCLES");
    end

    state_t               state_q;
    state_t               state_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q;
    logic [CNT_WIDTH-1:0] wait_cnt_d;

    logic mem_stall;
    logic lw_stall;
    logic hold;
    logic resolve;

    assign mem_stall = mem_req_M & ~mem_ready_M;
    assign lw_stall  = ResultSrcE0 & (RdE != '0) &
                       ((Rs1D == RdE) | (Rs2D == RdE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // hold freezes F..M and bubbles W; resolve applies branch/load-use rules
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        hold        = 1'b0;
        resolve     = 1'b0;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        mem_timeout = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_stall) begin
                    hold       = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = CNT_ONE;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_stall) begin
                    hold = 1'b1;
                    if (wait_cnt_q == TO_CNT) begin
                        state_d = TIMEOUT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_ONE;
                    end
                end else begin
                    // ready, or request withdrawn: both end the wait
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    resolve    = 1'b1;
                end
            end
            TIMEOUT: begin
                hold        = 1'b1;
                mem_timeout = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (resolve) begin
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        if (!rst_n) begin
            StallF      = 1'b0;
            StallD      = 1'b0;
            StallE      = 1'b0;
            StallM      = 1'b0;
            FlushD      = 1'b1;
            FlushE      = 1'b1;
            FlushW      = 1'b1;
            mem_timeout = 1'b0;
        end
    end

    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs
    );
        if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
            return 2'b10;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] stall_cnt_q;
    logic [DATA_WIDTH-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + DATA_WIDTH'(1);
            end
            if ((FlushD || FlushE) && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + DATA_WIDTH'(1);
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: table vectors, directed wait/timeout/reset sequences,
// and random stimulus against a cycle-level behavioural model.
module tb_hazard_sequencer;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       ResultSrcE0, PCSrcE, RegWriteM, RegWriteW;
    logic       mem_req_M, mem_ready_M;
    logic       StallF, StallD, StallE, StallM;
    logic       FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       mem_timeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_sequencer #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(7)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       ld, br, rwm, rww, req, rdy;
    } vin_t;

    typedef struct {
        vin_t        in;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic vin_t z();
        vin_t v;
        v.rs1d = 0; v.rs2d = 0; v.rs1e = 0; v.rs2e = 0;
        v.rde = 0; v.rdm = 0; v.rdw = 0;
        v.ld = 0; v.br = 0; v.rwm = 0; v.rww = 0;
        v.req = 0; v.rdy = 0;
        return v;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,FwdA,FwdB,timeout}
    function automatic logic [11:0] mk(
        input bit sf, input bit sd, input bit se, input bit sm,
        input bit fd, input bit fe, input bit fw,
        input logic [1:0] fa, input logic [1:0] fb, input bit to
    );
        return {sf, sd, se, sm, fd, fe, fw, fa, fb, to};
    endfunction

    function automatic logic [11:0] dut_out();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, mem_timeout};
    endfunction

    task automatic drive(input vin_t v);
        Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
        RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
        ResultSrcE0 = v.ld; PCSrcE = v.br;
        RegWriteM = v.rwm; RegWriteW = v.rww;
        mem_req_M = v.req; mem_ready_M = v.rdy;
    endtask

    task automatic check(input string name, input logic [11:0] got,
                         input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic add(input vin_t v, input logic [11:0] e, input string n);
        vec_t r;
        r.in = v; r.exp = e; r.name = n;
        tbl.push_back(r);
    endtask

    // Behavioural model: m_wait = wait cycles spent so far, m_to = timed out
    int m_wait;
    bit m_to;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait <= 0;
            m_to   <= 1'b0;
        end else if (!m_to) begin
            if (mem_req_M && !mem_ready_M) begin
                if (m_wait == 0)       m_wait <= 1;
                else if (m_wait == TO) m_to   <= 1'b1;
                else                   m_wait <= m_wait + 1;
            end else begin
                m_wait <= 0;
            end
        end
    end

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] model_out();
        logic [1:0] fa, fb;
        bit lw;
        fa = m_fwd(Rs1E);
        fb = m_fwd(Rs2E);
        lw = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        if (!rst_n)
            return mk(0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0);
        if (m_to)
            return mk(1, 1, 1, 1, 0, 0, 1, fa, fb, 1);
        if (mem_req_M && !mem_ready_M)
            return mk(1, 1, 1, 1, 0, 0, 1, fa, fb, 0);
        if (PCSrcE)
            return mk(0, 0, 0, 0, 1, 1, 0, fa, fb, 0);
        if (lw)
            return mk(1, 1, 0, 0, 0, 1, 0, fa, fb, 0);
        return mk(0, 0, 0, 0, 0, 0, 0, fa, fb, 0);
    endfunction

    task automatic step_check(input vin_t v, input string n,
                              input logic [11:0] e);
        drive(v);
        @(negedge clk);
        check(n, dut_out(), e);
        @(posedge clk);
        #1;
    endtask

    logic [11:0] RSTV, HOLD, ZERO;

    initial begin
        vin_t v;
        RSTV = mk(0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0);
        HOLD = mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
        ZERO = '0;

        add(z(), ZERO, "idle");
        v = z(); v.ld = 1; v.rde = 5; v.rs1d = 5;
        add(v, mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0), "loaduse_rs1");
        add(z(), ZERO, "loaduse_advanced");
        v = z(); v.ld = 1; v.rde = 9; v.rs2d = 9; v.rs1d = 3;
        add(v, mk(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0), "loaduse_rs2");
        v = z(); v.ld = 1; v.rde = 0; v.rs1d = 0;
        add(v, ZERO, "loaduse_x0");
        v = z(); v.ld = 0; v.rde = 5; v.rs1d = 5;
        add(v, ZERO, "nonload_match");
        v = z(); v.br = 1; v.ld = 1; v.rde = 5; v.rs1d = 5;
        add(v, mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), "branch_plus_lw");
        v = z(); v.br = 1;
        add(v, mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), "branch_only");
        v = z(); v.rdm = 7; v.rdw = 7; v.rwm = 1; v.rww = 1; v.rs1e = 7;
        add(v, mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "fwd_mem_wins");
        v.rwm = 0;
        add(v, mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0), "fwd_wb");
        v = z(); v.rdm = 0; v.rwm = 1; v.rdw = 0; v.rww = 1;
        add(v, ZERO, "fwd_x0");
        v = z(); v.rdw = 12; v.rww = 1; v.rs2e = 12; v.rdm = 4; v.rwm = 1;
        v.rs1e = 4;
        add(v, mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 0), "fwd_both_ops");
        v = z(); v.req = 1; v.rdy = 1;
        add(v, ZERO, "mem_ready_same_cycle");

        // reset behaviour, with hazard-provoking inputs present
        rst_n = 1'b0;
        v = z(); v.req = 1; v.rdm = 3; v.rwm = 1; v.rs1e = 3; v.br = 1;
        drive(v);
        #2;
        check("reset_outputs", dut_out(), RSTV);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step_check(tbl[i].in, tbl[i].name, tbl[i].exp);

        // memory wait: 3 stalled cycles (branch ignored), then ready
        v = z(); v.req = 1;
        step_check(v, "memwait_c0", HOLD);
        v.br = 1;
        step_check(v, "memwait_c1_br_ignored", HOLD);
        step_check(v, "memwait_c2_br_ignored", HOLD);
        v.rdy = 1;
        step_check(v, "memwait_ready_branch",
                   mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0));
        v = z(); v.req = 1; v.rdy = 1;
        step_check(v, "memwait_back_to_run", ZERO);

        // request withdrawn mid-wait counts as completion
        v = z(); v.req = 1;
        step_check(v, "drop_c0", HOLD);
        step_check(v, "drop_c1", HOLD);
        v.req = 0;
        step_check(v, "drop_release", ZERO);
        step_check(z(), "drop_idle", ZERO);

        // asynchronous reset mid-wait, no clock edge involved
        v = z(); v.req = 1;
        step_check(v, "areset_wait_c0", HOLD);
        step_check(v, "areset_wait_c1", HOLD);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_immediate", dut_out(), RSTV);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // timeout: stall begins in RUN, then 64 wait cycles, then TIMEOUT
        v = z(); v.req = 1;
        drive(v);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            check($sformatf("timeout_c%0d", i), dut_out(),
                  mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, i >= TO + 1));
            @(posedge clk);
            #1;
        end
        v.rdy = 1;
        step_check(v, "timeout_ignores_ready",
                   mk(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1));
        #3;
        rst_n = 1'b0;
        #1;
        check("timeout_reset_clears", dut_out(), RSTV);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step_check(z(), "after_timeout_reset", ZERO);

        // random stimulus against the model
        for (int n = 0; n < 2000; n++) begin
            v.rs1d = 5'($urandom_range(0, 3));
            v.rs2d = 5'($urandom_range(0, 3));
            v.rs1e = 5'($urandom_range(0, 3));
            v.rs2e = 5'($urandom_range(0, 3));
            v.rde  = 5'($urandom_range(0, 3));
            v.rdm  = 5'($urandom_range(0, 3));
            v.rdw  = 5'($urandom_range(0, 3));
            v.ld   = 1'($urandom_range(0, 1));
            v.br   = ($urandom_range(0, 3) == 0);
            v.rwm  = 1'($urandom_range(0, 1));
            v.rww  = 1'($urandom_range(0, 1));
            v.req  = 1'($urandom_range(0, 1));
            v.rdy  = ($urandom_range(0, 2) == 0);
            drive(v);
            @(negedge clk);
            check("random", dut_out(), model_out());
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("random_reset", dut_out(), RSTV);
            end
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
